// File: rtl/sliding_window_delay_if.sv
// Sample/config/result bundle for the sliding-window delay line.
// master drives samples and configuration; slave is the delay line itself.
interface sliding_window_delay_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 1,
    parameter int DW       = 5
);
    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      cfg_load;
    logic [DW-1:0]             depth_cfg;
    logic                      out_valid;
    logic [CHANNELS*WIDTH-1:0] out_new;
    logic [CHANNELS*WIDTH-1:0] out_old;
    logic                      out_old_valid;
    logic                      primed;
    logic [DW-1:0]             fill_count;
    logic [DW-1:0]             depth_active;
    logic                      cfg_error;

    modport master (
        output in_valid, in_data, cfg_load, depth_cfg,
        input  out_valid, out_new, out_old, out_old_valid,
        input  primed, fill_count, depth_active, cfg_error
    );

    modport slave (
        input  in_valid, in_data, cfg_load, depth_cfg,
        output out_valid, out_new, out_old, out_old_valid,
        output primed, fill_count, depth_active, cfg_error
    );
endinterface

// File: rtl/sliding_window_delay.sv
// Multi-channel programmable sample delay line for running window statistics.
// Each accepted sample is presented together with the sample it evicts, so
// downstream accumulators can do sum += new - old.
//
// state  | meaning
// FILL   | window holds fewer than depth_active samples; nothing is evicted
// PRIMED | window full; every accept evicts the sample depth_active accepts ago
module sliding_window_delay #(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 1,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sliding_window_delay_if.slave bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int CW = CHANNELS * WIDTH;
    localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    typedef enum logic {
        FILL   = 1'b0,
        PRIMED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]   fill_q, fill_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_new_q, out_new_d;
    logic [CW-1:0]   out_old_q, out_old_d;
    logic            out_old_valid_q, out_old_valid_d;
    logic            cfg_error_q, cfg_error_d;
    logic            wr_en;
    logic            cfg_ok;
    logic            ptr_at_end;
    logic [CW-1:0]   rd_data;
    logic [CW-1:0]   mem [MAX_DEPTH];

    // Window storage: not reset, every slot is written before it can be read out.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    // State, pointers and output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= FILL;
            wr_ptr_q        <= '0;
            fill_q          <= '0;
            depth_q         <= DW'(DEFAULT_DEPTH);
            out_valid_q     <= 1'b0;
            out_new_q       <= '0;
            out_old_q       <= '0;
            out_old_valid_q <= 1'b0;
            cfg_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            fill_q          <= fill_d;
            depth_q         <= depth_d;
            out_valid_q     <= out_valid_d;
            out_new_q       <= out_new_d;
            out_old_q       <= out_old_d;
            out_old_valid_q <= out_old_valid_d;
            cfg_error_q     <= cfg_error_d;
        end
    end

    // Next state: cfg_load wins over in_valid, so a sample arriving with a
    // reconfiguration is dropped rather than landing in the flushed window.
    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        fill_d          = fill_q;
        depth_d         = depth_q;
        out_valid_d     = 1'b0;
        out_new_d       = out_new_q;
        out_old_d       = out_old_q;
        out_old_valid_d = out_old_valid_q;
        cfg_error_d     = 1'b0;
        wr_en           = 1'b0;
        rd_data         = mem[wr_ptr_q];
        cfg_ok          = (bus.depth_cfg != '0) && (bus.depth_cfg <= DW'(MAX_DEPTH));
        ptr_at_end      = (DW'(wr_ptr_q) == (depth_q - DW'(1)));

        if (bus.cfg_load) begin
            if (cfg_ok) begin
                depth_d  = bus.depth_cfg;
                wr_ptr_d = '0;
                fill_d   = '0;
                state_d  = FILL;
            end else begin
                cfg_error_d = 1'b1;
            end
        end else if (bus.in_valid) begin
            wr_en           = 1'b1;
            out_valid_d     = 1'b1;
            out_new_d       = bus.in_data;
            out_old_valid_d = (state_q == PRIMED);
            out_old_d       = (state_q == PRIMED) ? rd_data : '0;
            wr_ptr_d        = ptr_at_end ? '0 : wr_ptr_q + PW'(1);
            if (state_q == FILL) begin
                fill_d = fill_q + DW'(1);
                if (fill_d == depth_q) begin
                    state_d = PRIMED;
                end
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.out_new       = out_new_q;
    assign bus.out_old       = out_old_q;
    assign bus.out_old_valid = out_old_valid_q;
    assign bus.primed        = (state_q == PRIMED);
    assign bus.fill_count    = fill_q;
    assign bus.depth_active  = depth_q;
    assign bus.cfg_error     = cfg_error_q;
endmodule

// File: tb/tb_sliding_window_delay.sv
// Bench for sliding_window_delay (CHANNELS=4, WIDTH=8, MAX_DEPTH=16).
// A queue-based window model provides expectations on every cycle; table
// vectors and hand-written sequences add fixed expected values.
module tb_sliding_window_delay;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sliding_window_delay_if #(.WIDTH(8), .CHANNELS(4), .DW(5)) bus ();

    sliding_window_delay #(
        .WIDTH(8), .CHANNELS(4), .MAX_DEPTH(16), .DEFAULT_DEPTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the window is a queue of the most recent samples.
    int          m_depth;
    logic [31:0] m_q[$];
    logic        m_ov, m_oldv, m_err;
    logic [31:0] m_new, m_old;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic cl,
                              input logic [4:0] dc, input logic rst_n);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (!rst_n) begin
            m_depth = 16; m_q.delete();
            m_new = 0; m_old = 0; m_oldv = 0;
        end else if (cl) begin
            if (dc >= 1 && dc <= 16) begin
                m_depth = int'(dc); m_q.delete();
            end else m_err = 1'b1;
        end else if (v) begin
            m_ov  = 1'b1;
            m_new = d;
            if (m_q.size() == m_depth) begin
                m_old = m_q.pop_front(); m_oldv = 1'b1;
            end else begin
                m_old = 0; m_oldv = 1'b0;
            end
            m_q.push_back(d);
        end
    endtask

    task automatic check_model();
        cmp("out_valid", 32'(bus.out_valid), 32'(m_ov));
        cmp("out_new", bus.out_new, m_new);
        cmp("out_old", bus.out_old, m_old);
        cmp("out_old_valid", 32'(bus.out_old_valid), 32'(m_oldv));
        cmp("primed", 32'(bus.primed), 32'(m_q.size() == m_depth));
        cmp("fill_count", 32'(bus.fill_count), 32'(m_q.size()));
        cmp("depth_active", 32'(bus.depth_active), 32'(m_depth));
        cmp("cfg_error", 32'(bus.cfg_error), 32'(m_err));
    endtask

    // One clock: drive inputs, take the edge, advance the model, check 1ns later.
    task automatic drive(input logic v, input logic [31:0] d, input logic cl,
                         input logic [4:0] dc, input logic rst_n);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.cfg_load  = cl;
        bus.depth_cfg = dc;
        reset         = rst_n;
        @(posedge clk);
        model_step(v, d, cl, dc, rst_n);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        cl;
        logic [4:0]  dc;
        logic        e_ov;
        logic [31:0] e_new;
        logic [31:0] e_old;
        logic        e_oldv;
        logic        e_pr;
        logic [4:0]  e_fill;
        logic [4:0]  e_dep;
        logic        e_err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 32'h0,        1'b1, 5'd1,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 5'd1, 1'b0};
        tbl[1]  = '{1'b1, 32'h5,        1'b0, 5'd0,  1'b1, 32'h5,        32'h0,        1'b0, 1'b1, 5'd1, 5'd1, 1'b0};
        tbl[2]  = '{1'b1, 32'h6,        1'b0, 5'd0,  1'b1, 32'h6,        32'h5,        1'b1, 1'b1, 5'd1, 5'd1, 1'b0};
        tbl[3]  = '{1'b1, 32'h7,        1'b0, 5'd0,  1'b1, 32'h7,        32'h6,        1'b1, 1'b1, 5'd1, 5'd1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h7,        32'h6,        1'b1, 1'b1, 5'd1, 5'd1, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 5'd0,  1'b0, 32'h7,        32'h6,        1'b1, 1'b1, 5'd1, 5'd1, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,        1'b1, 5'd17, 1'b0, 32'h7,        32'h6,        1'b1, 1'b1, 5'd1, 5'd1, 1'b1};
        tbl[7]  = '{1'b0, 32'h0,        1'b0, 5'd0,  1'b0, 32'h7,        32'h6,        1'b1, 1'b1, 5'd1, 5'd1, 1'b0};
        tbl[8]  = '{1'b1, 32'h9,        1'b1, 5'd2,  1'b0, 32'h7,        32'h6,        1'b1, 1'b0, 5'd0, 5'd2, 1'b0};
        tbl[9]  = '{1'b1, 32'hDDCCBBAA, 1'b0, 5'd0,  1'b1, 32'hDDCCBBAA, 32'h0,        1'b0, 1'b0, 5'd1, 5'd2, 1'b0};
        tbl[10] = '{1'b1, 32'h44332211, 1'b0, 5'd0,  1'b1, 32'h44332211, 32'h0,        1'b0, 1'b1, 5'd2, 5'd2, 1'b0};
        tbl[11] = '{1'b1, 32'h0F0E0D0C, 1'b0, 5'd0,  1'b1, 32'h0F0E0D0C, 32'hDDCCBBAA, 1'b1, 1'b1, 5'd2, 5'd2, 1'b0};

        m_depth = 16;
        m_new = 0; m_old = 0; m_oldv = 0; m_ov = 0; m_err = 0;

        // Reset and fill a depth-16 window with 1..20.
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            drive(1, 32'(i), 0, 0, 1);
            cmp("seq16_new", bus.out_new, 32'(i));
            cmp("seq16_primed", 32'(bus.primed), 32'(i >= 16));
            if (i <= 16) cmp("seq16_oldv", 32'(bus.out_old_valid), 32'h0);
            if (i == 17) cmp("seq16_old17", bus.out_old, 32'd1);
            if (i == 20) cmp("seq16_old20", bus.out_old, 32'd4);
        end

        // Gapped valid at depth 4: accept every third cycle.
        drive(0, 0, 1, 5'd4, 1);
        for (int k = 1; k <= 7; k++) begin
            drive(1, 32'(10 * k), 0, 0, 1);
            cmp("gap_ov", 32'(bus.out_valid), 32'h1);
            if (k == 5) cmp("gap_old50", bus.out_old, 32'd10);
            if (k == 7) cmp("gap_old70", bus.out_old, 32'd30);
            for (int j = 0; j < 2; j++) begin
                drive(0, 32'hFFFF_FFFF, 0, 0, 1);
                cmp("gap_idle_ov", 32'(bus.out_valid), 32'h0);
                cmp("gap_idle_fill", 32'(bus.fill_count), 32'(k < 4 ? k : 4));
            end
        end

        // Reconfigure to 3 with a colliding sample, then refill.
        drive(1, 32'd99, 1, 5'd3, 1);
        cmp("flush_ov", 32'(bus.out_valid), 32'h0);
        cmp("flush_fill", 32'(bus.fill_count), 32'h0);
        cmp("flush_primed", 32'(bus.primed), 32'h0);
        cmp("flush_depth", 32'(bus.depth_active), 32'd3);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 32'(100 + k), 0, 0, 1);
            cmp("flush_primed_after", 32'(bus.primed), 32'(k >= 3));
            if (k == 4) cmp("flush_old", bus.out_old, 32'd101);
        end

        // Table-driven vectors from a clean reset.
        drive(0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].cl, tbl[i].dc, 1);
            cmp($sformatf("tbl%0d_ov", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
            cmp($sformatf("tbl%0d_new", i), bus.out_new, tbl[i].e_new);
            cmp($sformatf("tbl%0d_old", i), bus.out_old, tbl[i].e_old);
            cmp($sformatf("tbl%0d_oldv", i), 32'(bus.out_old_valid), 32'(tbl[i].e_oldv));
            cmp($sformatf("tbl%0d_primed", i), 32'(bus.primed), 32'(tbl[i].e_pr));
            cmp($sformatf("tbl%0d_fill", i), 32'(bus.fill_count), 32'(tbl[i].e_fill));
            cmp($sformatf("tbl%0d_depth", i), 32'(bus.depth_active), 32'(tbl[i].e_dep));
            cmp($sformatf("tbl%0d_err", i), 32'(bus.cfg_error), 32'(tbl[i].e_err));
        end

        // Reset in the middle of a stream.
        drive(1, 32'h1234, 0, 0, 1);
        drive(1, 32'h5678, 0, 0, 0);
        cmp("rst_ov", 32'(bus.out_valid), 32'h0);
        cmp("rst_new", bus.out_new, 32'h0);
        cmp("rst_old", bus.out_old, 32'h0);
        cmp("rst_oldv", 32'(bus.out_old_valid), 32'h0);
        cmp("rst_primed", 32'(bus.primed), 32'h0);
        cmp("rst_fill", 32'(bus.fill_count), 32'h0);
        cmp("rst_depth", 32'(bus.depth_active), 32'd16);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [4:0]  dc;
            r  = $urandom_range(0, 199);
            dc = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                             : 5'($urandom_range(1, 6));
            drive($urandom_range(0, 3) != 0, $urandom, (r >= 2 && r < 8), dc, (r >= 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
